// File: rtl/fwd_sel_if.sv
// ID-stage hazard bus between the decode pipeline and the forwarding-select controller.
interface fwd_sel_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              hold;
  logic              flush;
  logic [2:0]        rs1_sel;
  logic [2:0]        rs2_sel;
  logic              stall_id;
  logic [CNT_W-1:0]  lu_stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_rd_we, id_is_load, hold, flush,
    input  rs1_sel, rs2_sel, stall_id, lu_stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_rd_we, id_is_load, hold, flush,
    output rs1_sel, rs2_sel, stall_id, lu_stall_cnt
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// Operand forwarding-select and load-use stall controller; tracks producers in
// EX/MEM/WB/PWB shadow stages and registers 8:1 operand-mux selects for EX.
module fwd_sel_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  fwd_sel_if.slave  bus
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } stage_t;

  localparam logic [2:0] SEL_RF     = 3'b000;
  localparam logic [2:0] SEL_MEM    = 3'b001;
  localparam logic [2:0] SEL_WB_ALU = 3'b010;
  localparam logic [2:0] SEL_WB_LD  = 3'b011;
  localparam logic [2:0] SEL_PWB    = 3'b100;

  // p1 = EX, p2 = MEM, p3 = WB, p4 = PWB shadows
  stage_t           stg_p1, stg_p2, stg_p3, stg_p4;
  logic [2:0]       rs1_sel_p1, rs2_sel_p1;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rs1_sel_nxt, rs2_sel_nxt;
  logic             stall;
  logic             unused_ok;

  function automatic logic is_prod(input stage_t s, input logic [REG_AW-1:0] a,
                                   input logic used);
    return used && s.vld && s.we && (s.rd == a) && (s.rd != '0);
  endfunction

  // Selects are computed one cycle ahead: EX shadow will be in MEM when the
  // consumer reaches EX, MEM shadow in WB, WB shadow in PWB.
  function automatic logic [2:0] resolve(input stage_t ex, input stage_t mem,
                                         input stage_t wb, input logic [REG_AW-1:0] a,
                                         input logic used);
    if (is_prod(ex, a, used))       return SEL_MEM;
    else if (is_prod(mem, a, used)) return mem.ld ? SEL_WB_LD : SEL_WB_ALU;
    else if (is_prod(wb, a, used))  return SEL_PWB;
    else                            return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    rs1_sel_nxt = resolve(stg_p1, stg_p2, stg_p3, bus.id_rs1, bus.id_rs1_used);
    rs2_sel_nxt = resolve(stg_p1, stg_p2, stg_p3, bus.id_rs2, bus.id_rs2_used);
    stall       = bus.id_valid & ~bus.hold & ~bus.flush & stg_p1.ld &
                  (is_prod(stg_p1, bus.id_rs1, bus.id_rs1_used) |
                   is_prod(stg_p1, bus.id_rs2, bus.id_rs2_used));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_p1     <= '0;
      stg_p2     <= '0;
      stg_p3     <= '0;
      stg_p4     <= '0;
      rs1_sel_p1 <= SEL_RF;
      rs2_sel_p1 <= SEL_RF;
      cnt        <= '0;
    end else if (!bus.hold) begin
      stg_p4 <= stg_p3;
      stg_p3 <= stg_p2;
      stg_p2 <= stg_p1;
      if (bus.flush || stall) begin
        stg_p1     <= '0;
        rs1_sel_p1 <= SEL_RF;
        rs2_sel_p1 <= SEL_RF;
      end else begin
        stg_p1     <= '{vld: bus.id_valid, rd: bus.id_rd,
                        we: bus.id_rd_we & bus.id_valid, ld: bus.id_is_load};
        rs1_sel_p1 <= rs1_sel_nxt;
        rs2_sel_p1 <= rs2_sel_nxt;
      end
      if (stall) cnt <= sat_inc(cnt);
    end
  end

  // PWB and the WB load flag are tracked for the pipeline picture but no select reads them.
  assign unused_ok = ^{stg_p3.ld, stg_p4};

  assign bus.rs1_sel      = rs1_sel_p1;
  assign bus.rs2_sel      = rs2_sel_p1;
  assign bus.stall_id     = stall;
  assign bus.lu_stall_cnt = cnt;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Bench for fwd_sel_ctrl: table of ID instructions with hand-derived expected
// stall/selects/counter, plus sequences for saturation and reset mid-hold.
module tb_fwd_sel_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic clk;
  logic rst_n;

  fwd_sel_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  fwd_sel_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    vld;
    int    rs1;
    bit    u1;
    int    rs2;
    bit    u2;
    int    rd;
    bit    we;
    bit    ld;
    bit    hold;
    bit    flush;
    bit    es;
    int    e1;
    int    e2;
    int    ec;
  } vec_t;

  typedef struct {
    string name;
    int    e1;
    int    e2;
    int    ec;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string n, bit v, int r1, bit u1, int r2, bit u2, int rd,
                              bit we, bit ld, bit h, bit f, bit es, int e1, int e2, int ec);
    vec_t x;
    x.name = n; x.vld = v; x.rs1 = r1; x.u1 = u1; x.rs2 = r2; x.u2 = u2; x.rd = rd;
    x.we = we; x.ld = ld; x.hold = h; x.flush = f; x.es = es; x.e1 = e1; x.e2 = e2; x.ec = ec;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid    = v.vld;
    bus.id_rs1      = AW'(v.rs1);
    bus.id_rs2      = AW'(v.rs2);
    bus.id_rs1_used = v.u1;
    bus.id_rs2_used = v.u2;
    bus.id_rd       = AW'(v.rd);
    bus.id_rd_we    = v.we;
    bus.id_is_load  = v.ld;
    bus.hold        = v.hold;
    bus.flush       = v.flush;
  endtask

  // Called at posedge+1: drive, check the combinational stall, then check the
  // registered outputs one edge later via the scoreboard.
  task automatic apply(input vec_t v);
    exp_t e;
    drive(v);
    #1;
    chk({v.name, " stall_id"}, int'(bus.stall_id), int'(v.es));
    e.name = v.name; e.e1 = v.e1; e.e2 = v.e2; e.ec = v.ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({v.name, " scoreboard"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, " rs1_sel"}, int'(bus.rs1_sel), e.e1);
      chk({e.name, " rs2_sel"}, int'(bus.rs2_sel), e.e2);
      chk({e.name, " lu_stall_cnt"}, int'(bus.lu_stall_cnt), e.ec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   c;
    //                name         vld rs1 u1 rs2 u2 rd we ld hd fl  es s1 s2 cnt
    vecs.push_back(mk("alu_prod",   1,  1, 1,  2, 1,  5, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("alu_b2b",    1,  5, 1,  7, 1,  6, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("lw_x8",      1,  1, 1,  0, 0,  8, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lu_stall",   1,  8, 1,  8, 1, 10, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("lu_after",   1,  8, 1,  8, 1, 10, 1, 0, 0, 0, 0, 3, 3, 1));
    vecs.push_back(mk("prod_x9",    1,  0, 1,  0, 1,  9, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("unrel_x11",  1,  1, 1,  2, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("dist2",      1,  9, 1, 11, 1, 12, 1, 0, 0, 0, 0, 2, 1, 1));
    vecs.push_back(mk("prod_x13",   1,  1, 1,  2, 1, 13, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("unrel_x14",  1,  1, 1,  2, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("unrel_x15",  1,  1, 1,  2, 1, 15, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("dist3",      1, 13, 1, 14, 1, 17, 1, 0, 0, 0, 0, 4, 2, 1));
    vecs.push_back(mk("prod_x0",    1,  1, 1,  2, 1,  0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("use_x0",     1,  0, 1,  0, 1, 18, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("x3_first",   1,  1, 1,  2, 1,  3, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("unrel_x16",  1,  1, 1,  2, 1, 16, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("x3_second",  1,  1, 1,  2, 1,  3, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("prio_unused",1,  3, 1, 16, 0, 19, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("invalid_id", 0,  1, 0,  2, 0, 20, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("after_inv",  1, 20, 1, 20, 1, 26, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("lw_x21",     1,  1, 1,  0, 0, 21, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("flush_lu",   1, 21, 1,  0, 0, 27, 1, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("post_flush", 1, 21, 1,  0, 0, 24, 1, 0, 0, 0, 0, 3, 0, 1));
    vecs.push_back(mk("lw_x22",     1, 21, 1,  0, 0, 22, 1, 1, 0, 0, 0, 4, 0, 1));
    vecs.push_back(mk("hold_lu_a",  1, 22, 1, 22, 1, 23, 1, 0, 1, 0, 0, 4, 0, 1));
    vecs.push_back(mk("hold_lu_b",  1, 22, 1, 22, 1, 23, 1, 0, 1, 0, 0, 4, 0, 1));
    vecs.push_back(mk("hold_lu_c",  1, 22, 1, 22, 1, 23, 1, 0, 1, 0, 0, 4, 0, 1));
    vecs.push_back(mk("rel_stall",  1, 22, 1, 22, 1, 23, 1, 0, 0, 0, 1, 0, 0, 2));
    vecs.push_back(mk("rel_after",  1, 22, 1, 22, 1, 23, 1, 0, 0, 0, 0, 3, 3, 2));

    rst_n = 1'b0;
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("reset rs1_sel", int'(bus.rs1_sel), 0);
    chk("reset rs2_sel", int'(bus.rs2_sel), 0);
    chk("reset lu_stall_cnt", int'(bus.lu_stall_cnt), 0);
    chk("reset stall_id", int'(bus.stall_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Drive the counter into saturation: 13 more stalls reach 15, the 14th must hold.
    c = 2;
    for (int i = 0; i < 14; i++) begin
      apply(mk("sat_lw", 1, 1, 1, 0, 0, 28, 1, 1, 0, 0, 0, 0, 0, c));
      c = (c < 15) ? c + 1 : 15;
      apply(mk("sat_stall", 1, 28, 1, 28, 1, 29, 1, 0, 0, 0, 1, 0, 0, c));
      apply(mk("sat_after", 1, 28, 1, 28, 1, 29, 1, 0, 0, 0, 0, 3, 3, c));
    end

    // Reset arriving mid-hold of a load-use pair, checked before any clock edge.
    apply(mk("rst_lw", 1, 1, 1, 0, 0, 25, 1, 1, 0, 0, 0, 0, 0, 15));
    v = mk("rst_hold", 1, 25, 1, 25, 1, 30, 1, 0, 1, 0, 0, 0, 0, 0);
    drive(v);
    #1;
    chk("rst_hold stall_id", int'(bus.stall_id), 0);
    #1;
    rst_n = 1'b0;
    bus.hold = 1'b0;
    #1;
    chk("async_rst rs1_sel", int'(bus.rs1_sel), 0);
    chk("async_rst rs2_sel", int'(bus.rs2_sel), 0);
    chk("async_rst lu_stall_cnt", int'(bus.lu_stall_cnt), 0);
    chk("async_rst stall_id", int'(bus.stall_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk("post_rst", 1, 25, 1, 25, 1, 30, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
FWD_SEL_CTRL -- requirements
Module: fwd_sel_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the load-use stall counter width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 id_valid  in  1  a real instruction is in ID.
REQ-006 id_rs1, id_rs2  in  REG_AW  source register addresses of the ID instruction.
REQ-007 id_rs1_used, id_rs2_used  in  1  the source operand is actually read.
REQ-008 id_rd  in  REG_AW  destination register of the ID instruction.
REQ-009 id_rd_we  in  1  the ID instruction writes id_rd.
REQ-010 id_is_load  in  1  the ID instruction is a load.
REQ-011 hold  in  1  global pipeline freeze, for example a memory wait.
REQ-012 flush  in  1  squash the instruction leaving ID, for example a taken branch.
REQ-013 rs1_sel, rs2_sel  out  3  registered 8:1 operand-mux selects, valid while the instruction is in EX.
REQ-014 stall_id  out  1  combinational; holds PC/ID and injects a bubble into EX.
REQ-015 lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 The block SHALL keep shadow stages EX, MEM, WB and PWB (one cycle after WB), each holding {valid, rd, we, is_load}.
REQ-017 Select encoding SHALL be:
  - 000: register file
  - 001: MEM-stage ALU result
  - 010: WB-stage ALU result
  - 011: WB-stage load data
  - 100: PWB write-back value
  - 101-111: never driven
REQ-018 A stage SHALL count as a producer for a source only if it is valid, has we=1, its rd equals the source address, the rd is nonzero, and the source's *_used is 1.
REQ-019 Each source's select SHALL follow youngest-first priority:
  - producer in the EX shadow: 001
  - else producer in MEM: 011 if that producer is a load, otherwise 010
  - else producer in WB: 100
  - else: 000
REQ-020 stall_id SHALL equal id_valid & ~hold & ~flush & (the EX shadow is a valid load producer for rs1 or rs2).
REQ-021 A load-use stall SHALL last exactly one cycle: after the stall, the load sits in MEM and select 011 applies.
REQ-022 When hold=1, all shadow stages, rs1_sel, rs2_sel and lu_stall_cnt SHALL keep their values.
REQ-023 When hold=0, PWB<=WB, WB<=MEM and MEM<=EX every cycle.
REQ-024 With hold=0 and stall_id=1, EX SHALL load a bubble (valid=0) and both selects SHALL load 000.
REQ-025 With hold=0 and flush=1, EX SHALL load a bubble and both selects SHALL load 000; flush SHALL take priority over stall.
REQ-026 Otherwise EX SHALL load {id_valid, id_rd, id_rd_we & id_valid, id_is_load} and the selects SHALL load the values computed per REQ-019.
REQ-027 rs1 and rs2 SHALL be resolved independently; a double hit on one producer SHALL give both sources the same code.
REQ-028 lu_stall_cnt SHALL increment on each cycle with stall_id=1 and SHALL saturate at all-ones with no wrap.
REQ-029 Latency: selects SHALL be registered, with one cycle from ID sampling to the output.

Reset
REQ-030 On rst_n=0, all shadow valid bits, rd, we and is_load SHALL clear immediately, independent of clk.
REQ-031 On rst_n=0, rs1_sel=000, rs2_sel=000 and lu_stall_cnt=0 SHALL apply immediately; stall_id SHALL read 0 because the EX shadow is invalid.
REQ-032 Reset asserted mid-stall or mid-hold SHALL discard all tracked producers; the first instruction after release SHALL receive 000/000.

Verification
REQ-033 ALU back-to-back: "add x5" then "sub x6,x5,x7" -> rs1_sel=001 and rs2_sel=000 in the consumer's EX cycle; stall_id never asserts.
REQ-034 Load-use: "lw x5" then "add x6,x5,x5" -> stall_id=1 for exactly 1 cycle; the consumer gets rs1_sel=rs2_sel=011; lu_stall_cnt increments 0->1.
REQ-035 Distance 2 and 3: producer x9 followed by 1 and then 2 unrelated instructions -> consumer rs1_sel=010 and 100 respectively; any rd=x0 producer -> 000.
REQ-036 Priority: ALU writes to x3 in both EX and WB shadows -> consumer rs1_sel=001.
REQ-037 hold=1 for 3 cycles during a load-use stall -> all outputs frozen, stall_id=0 while held; after release the sequence is identical to REQ-034.
REQ-038 flush coincident with load-use -> stall_id=0, EX bubble, selects 000; counter at 2^CNT_W-1 stays saturated on a further stall.
